// File: rtl/relu_grad_gate.sv
// ReLU forward pass that records a sign mask, and a backward pass that gates
// gradients with that mask. One-cycle registered output with valid/ready flow control.
module relu_grad_gate #(
  parameter int unsigned WIDTH          = 256,
  parameter logic [31:0] NEGATIVE_SLOPE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FWD, BWD, DRAIN} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  mask;
  logic              mask_valid;
  logic              pass_bwd;
  logic              xfer;
  logic              drain_ok;
  logic [31:0]       result;

  assign xfer     = in_valid && in_ready;
  assign drain_ok = (state == DRAIN) && (!out_valid || out_ready);

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !mode)
          state_nx = FWD;
        else if (start && mode && mask_valid)
          state_nx = BWD;
      end
      FWD, BWD: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && cnt == LAST)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (!out_valid || out_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    if (state == BWD)
      result = mask[cnt] ? in_data : '0;
    else
      result = in_data[31] ? NEGATIVE_SLOPE : in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mask       <= '0;
      mask_valid <= 1'b0;
      pass_bwd   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= (state == IDLE) && start && mode && !mask_valid;

      if (state == IDLE && start) begin
        cnt      <= '0;
        pass_bwd <= mode;
        if (!mode)
          mask_valid <= 1'b0;
      end else if (xfer && cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end

      if (xfer && state == FWD)
        mask[cnt] <= ~in_data[31];

      // Mask becomes usable only once a full forward pass has drained.
      if (drain_ok && !pass_bwd)
        mask_valid <= 1'b1;

      if (xfer) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_grad_gate.sv
// Directed, table-driven bench for relu_grad_gate (WIDTH=4, NEGATIVE_SLOPE=0).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_relu_grad_gate;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        err;

  relu_grad_gate #(
    .WIDTH          (4),
    .NEGATIVE_SLOPE (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        md;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic void add(input logic st, md, iv, input logic [31:0] d,
                              input logic ordy, e_ir, e_ov, input logic [31:0] e_od,
                              input logic e_busy, e_done, e_err);
    vec_t v;
    v.st = st; v.md = md; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    start     = v.st;
    mode      = v.md;
    in_valid  = v.iv;
    in_data   = v.d;
    out_ready = v.ordy;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.e_ir));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
    if (v.e_ov)
      chk({tag, ".out_data"}, out_data, v.e_od);
    chk({tag, ".busy"}, 32'(busy), 32'(v.e_busy));
    chk({tag, ".done"}, 32'(done), 32'(v.e_done));
    chk({tag, ".err"}, 32'(err), 32'(v.e_err));
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"}, out_data, 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
  endtask

  task automatic add_bwd_pass();
    add(1, 1, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0);
    add(0, 0, 1, 32'h4000_0000, 1, 1, 0, 32'h0,         1, 0, 0);
    add(0, 0, 1, 32'h4000_0000, 1, 1, 1, 32'h4000_0000, 1, 0, 0);
    add(0, 0, 1, 32'h4000_0000, 1, 1, 1, 32'h0000_0000, 1, 0, 0);
    add(0, 0, 1, 32'h4000_0000, 1, 1, 1, 32'h4000_0000, 1, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 1, 32'h0000_0000, 1, 1, 0);
    add(0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0);
  endtask

  vec_t hv;

  initial begin
    // Backward start straight after reset is rejected.
    add(1, 1, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0);
    add(0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 1);
    add(0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0);
    // Forward pass; start stays high with mode toggling and must be ignored.
    add(1, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0);
    add(1, 1, 1, 32'h3F80_0000, 1, 1, 0, 32'h0,         1, 0, 0);
    add(1, 0, 1, 32'hBF80_0000, 1, 1, 1, 32'h3F80_0000, 1, 0, 0);
    add(1, 1, 1, 32'h0000_0000, 1, 1, 1, 32'h0000_0000, 1, 0, 0);
    add(1, 0, 1, 32'h8000_0000, 1, 1, 1, 32'h0000_0000, 1, 0, 0);
    add(1, 1, 1, 32'hDEAD_BEEF, 1, 0, 1, 32'h0000_0000, 1, 1, 0);
    add(0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0);
    // Two identical backward passes; mask is {1,0,1,0}.
    add_bwd_pass();
    add_bwd_pass();
    // Backward pass with a 5-cycle downstream stall.
    add(1, 1, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0);
    add(0, 0, 1, 32'h1111_1111, 1, 1, 0, 32'h0,         1, 0, 0);
    add(0, 0, 1, 32'h2222_2222, 1, 1, 1, 32'h1111_1111, 1, 0, 0);
    for (int unsigned i = 0; i < 5; i++)
      add(0, 0, 1, 32'h3333_3333, 0, 0, 1, 32'h0000_0000, 1, 0, 0);
    add(0, 0, 1, 32'h3333_3333, 1, 1, 1, 32'h0000_0000, 1, 0, 0);
    add(0, 0, 1, 32'h4444_4444, 1, 1, 1, 32'h3333_3333, 1, 0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 1, 32'h0000_0000, 1, 0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 1, 32'h0000_0000, 1, 1, 0);
    add(0, 0, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0);

    reset = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int unsigned i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted mid-pass after two forward transfers.
    hv = '{1, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0};
    step(hv, "rst.start");
    hv = '{0, 0, 1, 32'h3F80_0000, 1, 1, 0, 32'h0, 1, 0, 0};
    step(hv, "rst.x0");
    hv = '{0, 0, 1, 32'h4000_0000, 1, 1, 1, 32'h3F80_0000, 1, 0, 0};
    step(hv, "rst.x1");
    #2 reset = 1'b0;
    #1 check_all_zero("rst.async");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst.held");
    start = 1'b0; in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    hv = '{1, 1, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0};
    step(hv, "rst.bwd");
    hv = '{0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 1};
    step(hv, "rst.err");
    hv = '{0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0};
    step(hv, "rst.idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/relu_grad_gate.md
RELU_GRAD_GATE -- requirements
Module: relu_grad_gate

Interface
REQ-001 Parameter WIDTH, default 256, SHALL set the number of 32-bit float elements per vector pass.
REQ-002 Parameter NEGATIVE_SLOPE, default 0, SHALL be the 32-bit pattern output in forward mode for negative inputs.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-low; reset asserted while low.
REQ-005 start  input  1  SHALL request a pass when high in IDLE.
REQ-006 mode  input  1  SHALL select the pass type at start: 0 = forward, 1 = backward.
REQ-007 in_valid  input  1  SHALL qualify in_data.
REQ-008 in_ready  output  1  SHALL indicate the block accepts in_data this cycle.
REQ-009 in_data  input  32  SHALL carry forward activations or backward gradients, IEEE-754 single.
REQ-010 out_valid  output  1  SHALL qualify out_data.
REQ-011 out_ready  input  1  SHALL indicate downstream accepts out_data this cycle.
REQ-012 out_data  output  32  SHALL carry the ReLU result or gated gradient.
REQ-013 busy  output  1  SHALL be high in any state other than IDLE.
REQ-014 done  output  1  SHALL pulse high one cycle when a pass completes.
REQ-015 err  output  1  SHALL pulse high one cycle when a backward start is rejected.

Function
REQ-016 States SHALL be IDLE, FWD, BWD, DRAIN; an element transfer occurs on any cycle with in_valid && in_ready.
REQ-017 IDLE, start=1, mode=0 -> FWD next cycle; element counter cleared; mask_valid cleared.
REQ-018 IDLE, start=1, mode=1, mask_valid=1 -> BWD next cycle; element counter cleared.
REQ-019 IDLE, start=1, mode=1, mask_valid=0 -> stay IDLE; err=1 the next cycle.
REQ-020 start SHALL be ignored outside IDLE; mode SHALL be sampled only with an accepted start.
REQ-021 in_ready SHALL equal (state is FWD or BWD) && (!out_valid || out_ready); in_ready SHALL be 0 in IDLE and DRAIN.
REQ-022 Forward transfer of element at index i: mask[i] <= (in_data[31]==0); out_data <= in_data if in_data[31]==0, else NEGATIVE_SLOPE; +0.0 passes, -0.0 outputs NEGATIVE_SLOPE.
REQ-023 Backward transfer of element at index i: out_data <= mask[i] ? in_data : 32'h0000_0000; mask SHALL be unchanged.
REQ-024 Latency SHALL be one cycle: out_valid goes high the cycle after the transfer.
REQ-025 out_valid && out_ready with no new transfer SHALL clear out_valid; with a simultaneous transfer SHALL keep out_valid high with the new data.
REQ-026 out_valid && !out_ready SHALL hold out_data and out_valid stable.
REQ-027 Element counter SHALL be $clog2(WIDTH) bits, increment per transfer, and never wrap within a pass.
REQ-028 Transfer at index WIDTH-1 SHALL move FWD/BWD -> DRAIN.
REQ-029 In DRAIN, the cycle the output register empties (out_valid && out_ready, or already empty) SHALL pulse done and return to IDLE.
REQ-030 Completion of a forward pass SHALL set mask_valid=1; mask_valid SHALL persist across any number of backward passes.
REQ-031 Indexing SHALL be identical in both modes: the k-th transfer of a pass uses mask[k].

Reset
REQ-032 While reset is low: state=IDLE, counter=0, mask all 0, mask_valid=0, out_data=0, out_valid=0, in_ready=0, busy=0, done=0, err=0.
REQ-033 Reset asserted mid-pass SHALL abort the pass immediately; a following backward start SHALL be rejected with err.

Verification (WIDTH=4, NEGATIVE_SLOPE=0)
REQ-034 Backward start after reset -> err=1 one cycle, busy stays 0, no in_ready.
REQ-035 Forward pass in {3F80_0000, BF80_0000, 0000_0000, 8000_0000}, out_ready=1 -> out {3F80_0000, 0, 0, 0} one cycle after each transfer, done once.
REQ-036 Then backward pass in {4000_0000, 4000_0000, 4000_0000, 4000_0000} -> out {4000_0000, 0, 4000_0000, 0}; repeating the backward pass gives identical output.
REQ-037 out_ready held 0 for 5 cycles mid-pass -> out_data/out_valid stable, in_ready=0, no element lost or duplicated.
REQ-038 Reset pulsed after 2 forward transfers -> all outputs 0; next backward start -> err.
REQ-039 start held high during a pass, with mode toggling -> ignored; exactly one done per pass.
